// File: rtl/shift_scheduler_pkg.sv
// Shared width derivations and packed-port slicing helpers for shift_scheduler
// and the producers that flatten their operands onto its request ports.
package shift_scheduler_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction

  function automatic int unsigned word_width(input int unsigned logword);
    return 32'(1) << logword;
  endfunction

  function automatic int unsigned id_width(input int unsigned nreq);
    return (clog2(nreq) < 1) ? 1 : clog2(nreq);
  endfunction

  // Requester k's word sits at [word_lsb(k) +: WORD], its shift at [amount_lsb(k) +: LOGWORD].
  function automatic int unsigned word_lsb(input int unsigned k, input int unsigned logword);
    return k << logword;
  endfunction

  function automatic int unsigned amount_lsb(input int unsigned k, input int unsigned logword);
    return k * logword;
  endfunction

endpackage

// File: rtl/RightShift.sv
// Logarithmic barrel shifter: logical right shift with zero fill.
module RightShift #(
  parameter int unsigned LOGWORD = 5
) (
  input  logic [(1<<LOGWORD)-1:0] value,
  input  logic [LOGWORD-1:0]      amount,
  output logic [(1<<LOGWORD)-1:0] result
);

  logic [(1<<LOGWORD)-1:0] stage;

  always_comb begin
    stage = value;
    for (int unsigned s = 0; s < LOGWORD; s++) begin
      if (amount[s]) stage = stage >> (32'(1) << s);
    end
    result = stage;
  end

endmodule

// File: rtl/shift_scheduler_rr_arbiter.sv
// Round-robin arbiter: scans req_valid from ptr upward with wraparound; ptr
// moves past the winner only when the caller strobes advance.
module rr_arbiter
  import shift_scheduler_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req_valid,
  input  logic            enable,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  g,
  output logic            any
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] idx;

  always_comb begin
    grant = '0;
    g     = '0;
    any   = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = IDW'((32'(ptr) + i) % NREQ);
      if (!any && req_valid[idx]) begin
        any = 1'b1;
        g   = idx;
      end
    end
    if (enable && any) grant = NREQ'(1) << g;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (g == IDW'(NREQ - 1)) ? '0 : g + IDW'(1);
    end
  end

endmodule

// File: rtl/shift_scheduler.sv
// Shares one barrel right shifter among NREQ valid/ready requesters, granting
// round-robin and registering result plus winner index behind out_ready.
module shift_scheduler
  import shift_scheduler_pkg::*;
#(
  parameter  int unsigned LOGWORD = 5,
  parameter  int unsigned NREQ    = 4,
  localparam int unsigned WORD    = word_width(LOGWORD),
  localparam int unsigned IDW     = id_width(NREQ)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WORD-1:0]    req_value,
  input  logic [NREQ*LOGWORD-1:0] req_amount,
  output logic [NREQ-1:0]         req_ready,
  output logic                    out_valid,
  output logic [WORD-1:0]         out_value,
  output logic [IDW-1:0]          out_id,
  input  logic                    out_ready
);

  logic              load;
  logic              any;
  logic              transfer;
  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    g;
  logic [WORD-1:0]   sel_value;
  logic [LOGWORD-1:0] sel_amount;
  logic [WORD-1:0]   shifted;

  // reset_n folded into load keeps req_ready low throughout reset
  assign load      = reset_n && (!out_valid || out_ready);
  assign transfer  = load && any;
  assign req_ready = grant;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arbiter (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .enable    (load),
    .advance   (transfer),
    .grant     (grant),
    .g         (g),
    .any       (any)
  );

  always_comb begin
    sel_value  = '0;
    sel_amount = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (g == IDW'(k)) begin
        sel_value  = req_value[word_lsb(k, LOGWORD) +: WORD];
        sel_amount = req_amount[amount_lsb(k, LOGWORD) +: LOGWORD];
      end
    end
  end

  RightShift #(
    .LOGWORD (LOGWORD)
  ) u_shift (
    .value  (sel_value),
    .amount (sel_amount),
    .result (shifted)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_value <= '0;
      out_id    <= '0;
    end else if (load) begin
      out_valid <= transfer;
      if (transfer) begin
        out_value <= shifted;
        out_id    <= g;
      end
    end
  end

endmodule

// File: tb/tb_shift_scheduler.sv
// Self-checking bench for shift_scheduler (LOGWORD=3, NREQ=4) with a
// reference model and a result scoreboard checked at each consumption.
module tb_shift_scheduler;

  localparam int unsigned LW = 3;
  localparam int unsigned NR = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [31:0]   req_value = '0;
  logic [11:0]   req_amount = '0;
  logic [NR-1:0] req_ready;
  logic          out_valid;
  logic [7:0]    out_value;
  logic [1:0]    out_id;
  logic          out_ready = 1'b0;

  typedef struct packed { logic [1:0] id; logic [7:0] value; } result_t;

  result_t    sb[$];
  logic [7:0] val[NR];
  logic [2:0] amt[NR];
  int         mptr;
  logic       mvalid;
  logic [NR-1:0] last_ready;
  int         checks = 0;
  int         errors = 0;

  shift_scheduler #(.LOGWORD(LW), .NREQ(NR)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_value(req_value),
    .req_amount(req_amount), .req_ready(req_ready), .out_valid(out_valid),
    .out_value(out_value), .out_id(out_id), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  // Drive one cycle, predict grant and result, and score consumed results.
  task automatic step(input logic [NR-1:0] v, input logic oready);
    logic load, found;
    logic [1:0] g, idx;
    logic [NR-1:0] exp_ready;
    for (int k = 0; k < NR; k++) begin
      req_value[k*8 +: 8]  = val[k];
      req_amount[k*3 +: 3] = amt[k];
    end
    req_valid = v;
    out_ready = oready;
    #2;
    load = !mvalid || oready;
    found = 1'b0;
    g = '0;
    if (load) begin
      for (int i = 0; i < NR; i++) begin
        idx = 2'((mptr + i) % NR);
        if (!found && v[idx]) begin found = 1'b1; g = idx; end
      end
    end
    exp_ready = found ? (4'b0001 << g) : 4'b0000;
    last_ready = exp_ready;
    checks++;
    if (req_ready !== exp_ready) begin
      errors++; $display("FAIL req_ready: got %b expected %b", req_ready, exp_ready);
    end
    if (mvalid && oready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL scoreboard: consumption with empty queue");
      end else begin
        if (out_value !== sb[0].value || out_id !== sb[0].id) begin
          errors++;
          $display("FAIL result: got id %0d value %h expected id %0d value %h",
                   out_id, out_value, sb[0].id, sb[0].value);
        end
        void'(sb.pop_front());
      end
    end
    if (found) begin
      sb.push_back({g, val[g] >> amt[g]});
      mptr = (int'(g) + 1) % NR;
      mvalid = 1'b1;
    end else if (load) begin
      mvalid = 1'b0;
    end
    @(posedge clock);
    #1;
    checks++;
    if (out_valid !== mvalid) begin
      errors++; $display("FAIL out_valid: got %b expected %b", out_valid, mvalid);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    sb.delete();
    mptr = 0;
    mvalid = 1'b0;
  endtask

  task automatic test_reset();
    val[0] = 8'h5A; amt[0] = 3'd0;
    step(4'b0001, 1'b0);
    checks++;
    if (out_value !== 8'h5A || out_valid !== 1'b1) begin
      errors++; $display("FAIL preload: got valid %b value %h expected 1 5a", out_valid, out_value);
    end
    req_valid = 4'b1111;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_value !== 8'h00 || out_id !== 2'd0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: got valid %b value %h id %0d ready %b expected all zero",
               out_valid, out_value, out_id, req_ready);
    end
    #1;
    reset_n = 1'b1;
    sb.delete();
    mptr = 0;
    mvalid = 1'b0;
    for (int k = 0; k < NR; k++) begin val[k] = 8'(8'h11 * (k + 1)); amt[k] = 3'd1; end
    step(4'b1111, 1'b1);
    checks++;
    if (out_id !== 2'd0 || out_value !== 8'h08) begin
      errors++; $display("FAIL first_grant: got id %0d value %h expected 0 08", out_id, out_value);
    end
  endtask

  task automatic test_single();
    logic [2:0]  amts[3] = '{3'd3, 3'd0, 3'd7};
    logic [7:0]  exps[3] = '{8'h16, 8'hB4, 8'h01};
    for (int t = 0; t < 3; t++) begin
      val[2] = 8'hB4; amt[2] = amts[t];
      step(4'b0100, 1'b1);
      checks++;
      if (last_ready !== 4'b0100 || out_value !== exps[t] || out_id !== 2'd2) begin
        errors++;
        $display("FAIL single amt %0d: got ready %b value %h id %0d expected 0100 %h 2",
                 amts[t], last_ready, out_value, out_id, exps[t]);
      end
    end
  endtask

  task automatic test_round_robin();
    int start;
    start = mptr;
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 1'b1);
      checks++;
      if (out_id !== 2'((start + i) % NR) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL round_robin %0d: got id %0d valid %b expected %0d 1",
                 i, out_id, out_valid, (start + i) % NR);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] held_value;
    logic [1:0] held_id;
    step(4'b1111, 1'b0);
    held_value = out_value;
    held_id = out_id;
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b0);
      checks++;
      if (req_ready !== 4'b0000 || out_value !== held_value || out_id !== held_id) begin
        errors++;
        $display("FAIL backpressure %0d: got ready %b value %h id %0d expected 0000 %h %0d",
                 i, req_ready, out_value, out_id, held_value, held_id);
      end
    end
    step(4'b1111, 1'b1);
    checks++;
    if (out_id !== held_id + 2'd1) begin
      errors++; $display("FAIL release: got id %0d expected %0d", out_id, held_id + 2'd1);
    end
  endtask

  task automatic test_skip();
    logic [1:0] exp_ids[3] = '{2'd1, 2'd3, 2'd1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(4'b1010, 1'b1);
      checks++;
      if (out_id !== exp_ids[i] || (last_ready & 4'b0101) !== 4'b0000) begin
        errors++;
        $display("FAIL skip %0d: got id %0d expected %0d", i, out_id, exp_ids[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [NR-1:0] pend;
    for (int i = 0; i < 4; i++) begin
      val[0] = 8'(8'hC3 + i); amt[0] = 3'(i);
      step(4'b0001, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_value !== (8'(8'hC3 + i) >> i)) begin
        errors++;
        $display("FAIL back_to_back %0d: got valid %b value %h expected 1 %h",
                 i, out_valid, out_value, 8'(8'hC3 + i) >> i);
      end
    end
    pend = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < NR; k++) begin
        if (!pend[k] && $urandom_range(0, 2) != 0) begin
          pend[k] = 1'b1;
          val[k] = 8'($urandom);
          amt[k] = 3'($urandom);
        end
      end
      step(pend, 1'($urandom));
      pend = pend & ~last_ready;
    end
  endtask

  initial begin
    mptr = 0;
    mvalid = 1'b0;
    last_ready = '0;
    for (int k = 0; k < NR; k++) begin val[k] = '0; amt[k] = '0; end
    #3;
    checks++;
    if (out_valid !== 1'b0 || out_value !== 8'h00 || out_id !== 2'd0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: got valid %b value %h id %0d ready %b expected zeros",
               out_valid, out_value, out_id, req_ready);
    end
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_skip();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
